// File: rtl/dac_seq_pkg.sv
// Shared types and defaults for the DAC TX sequencer.
package dac_seq_pkg;

  typedef enum logic [1:0] {IDLE, LEAD, RUN, FLUSH} state_t;

  // One complex baseband sample; Q occupies the upper half of the bus.
  typedef struct packed {
    logic signed [15:0] q;
    logic signed [15:0] i;
  } sample_t;

  localparam int LEAD_DEF  = 16;
  localparam int FLUSH_DEF = 4096;

endpackage

// File: rtl/dac_pace_timer.sv
// Sample pacing down-counter: strobes when the count is zero, reloads to
// period-1 afterwards. 'hold' freezes the count at zero (stalled strobe),
// 'clear' parks it at zero so the first strobe fires as soon as 'en' rises.
module dac_pace_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             hold,
  input  logic [CNT_W-1:0] period,
  output logic             strobe
);

  logic [CNT_W-1:0] cnt;

  assign strobe = en && (cnt == '0);

  // Count down once per clock, reload on a strobe unless held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (en) begin
      if (cnt == '0) begin
        if (!hold) cnt <= period - CNT_W'(1);
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dac_tx_sequencer.sv
// DAC TX sequencer: paces IFFT samples to the DAC chain, marks symbol ends
// with tlast, and owns the downlink enable with lead-in and flush tail.
// Build option DAC_SEQ_ZERO_FILL_EN: a starved strobe emits a zero sample
// instead of stalling the pace counter.
module dac_tx_sequencer
  import dac_seq_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 16,
  parameter int SYM_W        = 16,
  parameter int LEAD_CYCLES  = LEAD_DEF,
  parameter int FLUSH_CYCLES = FLUSH_DEF
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  fs_cycles,
  input  logic [CNT_W-1:0]  sym_len,
  input  logic [SYM_W-1:0]  num_symbols,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              dl_en,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic              late,
  output logic [SYM_W-1:0]  sym_idx
);

  state_t           state;
  logic [CNT_W-1:0] fs_r, sl_r;
  logic [SYM_W-1:0] ns_r;
  logic [CNT_W-1:0] lead_cnt, flush_cnt, smp_idx;
  logic [SYM_W-1:0] ld_sym;   // symbols whose samples have all been loaded
  logic             last_ld;  // final sample of the frame is in the output reg
  logic             strobe, stall_out, take, load_en, hold, sym_end, start_ok;

`ifdef DAC_SEQ_ZERO_FILL_EN
  localparam sample_t ZERO_SMP = '{q: 16'sd0, i: 16'sd0};
`endif

  assign start_ok  = start && !abort && (state == IDLE) &&
                     (sym_len != '0) && (num_symbols != '0);
  assign stall_out = m_axis_tvalid && !m_axis_tready;
  // A strobe is usable only while the frame still needs samples and the
  // previous beat has drained; otherwise it is skipped.
  assign take      = strobe && !last_ld && !stall_out;
  assign sym_end   = (smp_idx == sl_r - CNT_W'(1));

`ifdef DAC_SEQ_ZERO_FILL_EN
  assign load_en = take;
  assign hold    = 1'b0;
`else
  assign load_en = take && s_axis_tvalid;
  assign hold    = take && !s_axis_tvalid;
`endif

  assign s_axis_tready = take && s_axis_tvalid;
  assign busy          = (state != IDLE);

  dac_pace_timer #(.CNT_W(CNT_W)) u_pace (
    .clk    (aclk),
    .rst_n  (aresetn),
    .en     (state == RUN),
    .clear  (state != RUN),
    .hold   (hold),
    .period (fs_r),
    .strobe (strobe)
  );

  // Frame FSM with registered outputs, output beat register and stickies.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      fs_r          <= '0;
      sl_r          <= '0;
      ns_r          <= '0;
      lead_cnt      <= '0;
      flush_cnt     <= '0;
      smp_idx       <= '0;
      ld_sym        <= '0;
      last_ld       <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      dl_en         <= 1'b0;
      done          <= 1'b0;
      underrun      <= 1'b0;
      late          <= 1'b0;
      sym_idx       <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state         <= IDLE;
        dl_en         <= 1'b0;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        last_ld       <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start_ok) begin
            state    <= LEAD;
            fs_r     <= (fs_cycles < CNT_W'(2)) ? CNT_W'(1) : fs_cycles;
            sl_r     <= sym_len;
            ns_r     <= num_symbols;
            dl_en    <= 1'b1;
            underrun <= 1'b0;
            late     <= 1'b0;
            lead_cnt <= '0;
            smp_idx  <= '0;
            ld_sym   <= '0;
            last_ld  <= 1'b0;
            sym_idx  <= '0;
          end
          LEAD: begin
            if (lead_cnt == CNT_W'(LEAD_CYCLES - 1)) state <= RUN;
            else lead_cnt <= lead_cnt + CNT_W'(1);
          end
          RUN: begin
            // Downstream handshake retires the current beat.
            if (m_axis_tvalid && m_axis_tready) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              if (m_axis_tlast) begin
                if (last_ld) begin
                  state     <= FLUSH;
                  flush_cnt <= '0;
                end else begin
                  sym_idx <= sym_idx + SYM_W'(1);
                end
              end
            end
            if (strobe && !last_ld && stall_out) late <= 1'b1;
            if (take && !s_axis_tvalid) underrun <= 1'b1;
            // Load a new beat; placed after the retire so it takes priority.
            if (load_en) begin
`ifdef DAC_SEQ_ZERO_FILL_EN
              m_axis_tdata <= s_axis_tvalid ? s_axis_tdata : DATA_W'(ZERO_SMP);
`else
              m_axis_tdata <= s_axis_tdata;
`endif
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= sym_end;
              if (sym_end) begin
                smp_idx <= '0;
                ld_sym  <= ld_sym + SYM_W'(1);
                if (ld_sym == ns_r - SYM_W'(1)) last_ld <= 1'b1;
              end else begin
                smp_idx <= smp_idx + CNT_W'(1);
              end
            end
          end
          FLUSH: begin
            if (flush_cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
              state <= IDLE;
              dl_en <= 1'b0;
              done  <= 1'b1;
            end else begin
              flush_cnt <= flush_cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/dac_tx_sequencer.md
Name: dac_tx_sequencer

Overview:
- Paces IFFT/CP-inserted baseband samples into the DAC chain at one sample per fs_cycles clocks.
- Asserts tlast on each OFDM symbol boundary and counts symbols per frame.
- Owns the DAC chain downlink enable (dl_en): raises it at frame start, holds it through a filter-flush tail, then drops it.
- Sits between the IFFT output stream and the DAC chain AXIS input; configured per frame by the PS register block.

Parameters:
DATA_W, 32, sample width ({Q[31:16], I[15:0]})
CNT_W, 16, width of fs_cycles / sym_len / flush counters
SYM_W, 16, width of symbol counter
LEAD_CYCLES, 16, clocks dl_en is high before the first sample strobe
FLUSH_CYCLES, 4096, clocks dl_en stays high after the last sample is accepted

Ports:
aclk  in  1  system clock (100 MHz)
aresetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latch config and begin a frame
abort  in  1  one-cycle pulse; terminate the frame immediately
fs_cycles  in  CNT_W  clocks per output sample
sym_len  in  CNT_W  samples per symbol (nfft+cp_len)
num_symbols  in  SYM_W  symbols per frame
s_axis_tdata  in  DATA_W  sample from IFFT
s_axis_tvalid  in  1  source valid
s_axis_tready  out  1  sample consumed this cycle
m_axis_tdata  out  DATA_W  sample to DAC chain
m_axis_tvalid  out  1  sample valid
m_axis_tlast  out  1  last sample of a symbol
m_axis_tready  in  1  DAC chain ready
dl_en  out  1  DAC chain downlink enable
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at normal frame completion
underrun  out  1  sticky; cleared on start
late  out  1  sticky; strobe occurred while previous beat still pending; cleared on start
sym_idx  out  SYM_W  index of the symbol currently being sent

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset mid-frame aborts silently; done is not asserted.
- FSM states: IDLE, LEAD, RUN, FLUSH.
- IDLE -> LEAD on start, provided sym_len != 0 and num_symbols != 0. Otherwise start is ignored.
  - On start, latch config; fs_cycles values 0 and 1 are both treated as 1.
  - Clear underrun/late.
  - dl_en rises on the cycle after start.
- LEAD: count LEAD_CYCLES, then -> RUN, with the pace counter set so the first strobe occurs on RUN entry.
- RUN, pace counter (0..fs_cycles-1): strobe when the counter is 0.
  - On strobe with s_axis_tvalid=1: s_axis_tready=1 for that cycle only; the sample registers to m_axis_tdata; m_axis_tvalid=1 on the next cycle.
  - m_axis_tvalid holds until m_axis_tready; tdata/tlast are stable while valid and not ready.
  - Strobe while m_axis_tvalid && !m_axis_tready: sample is not taken; late<=1; the strobe is counted as skipped (sample index not advanced).
  - Sample counter 0..sym_len-1. m_axis_tlast=1 when the loaded sample index equals sym_len-1; on that beat the counter wraps and sym_idx increments.
  - After the beat with tlast and sym_idx==num_symbols-1 is accepted -> FLUSH.
- FLUSH: dl_en held FLUSH_CYCLES, then dl_en<=0, done pulse for 1 cycle, -> IDLE.
- abort (any non-IDLE state) -> IDLE the next cycle: dl_en, m_axis_tvalid, and tlast drop to 0; no done. start and abort together: abort wins. start while busy: ignored.
- Throughput: at most one sample per strobe. Latency from strobe to m_axis_tvalid is 1 clock.

Optional Feature:
DAC_SEQ_ZERO_FILL_EN
- Defined: strobe with s_axis_tvalid=0 emits a zero sample (I=Q=0), advances the sample index (tlast rules apply), and sets underrun. Symbol timing is preserved.
- Undefined: strobe with s_axis_tvalid=0 sets underrun and stalls. The pace counter holds at 0 until s_axis_tvalid; the sample is taken then, and pacing restarts from that cycle.

Decomposition:
- Package dac_seq_pkg: state enum (IDLE, LEAD, RUN, FLUSH), sample typedef (struct of signed 16-bit i, q), default LEAD/FLUSH constants.
- Sub-module dac_pace_timer: fs_cycles down-counter producing a strobe, with load/hold inputs. All other logic lives in the top.

Test Plan:
- fs_cycles=10, sym_len=4, num_symbols=2, tready=1, source always valid -> 8 beats exactly 10 clocks apart; tlast on beats 4 and 8; dl_en high LEAD_CYCLES before beat 1 and FLUSH_CYCLES after beat 8; single done pulse.
- fs_cycles=0 -> beats on consecutive cycles; s_axis_tready one cycle per beat.
- Hold m_axis_tready=0 for 25 clocks, fs_cycles=10 -> data/tlast stable; late=1; 2 strobes skipped; sample order preserved.
- Drop s_axis_tvalid for one strobe -> underrun=1. With DAC_SEQ_ZERO_FILL_EN: a zero beat is inserted and the frame length is unchanged. Without it: the beat is delayed and subsequent spacing re-anchors to the accept cycle.
- abort in mid-RUN -> next cycle dl_en=0, m_axis_tvalid=0, busy=0, no done. A following start with sym_len=4, num_symbols=1 -> clean 4-beat frame, sym_idx starts at 0.
- start with num_symbols=0 -> ignored: busy stays 0, dl_en stays 0. aresetn pulsed in FLUSH -> all outputs 0 immediately.
